// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        HDR_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int ADDR_SHIFT     = 2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream into big-endian 32-bit words; the first byte ends up in [31:24].
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    // Only the three most recent bytes are stored; the fourth is the live input.
    logic [23:0] r_word;
    logic [1:0]  r_byte_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_word     <= '0;
            r_byte_cnt <= '0;
        end else if (shift_i) begin
            r_word     <= {r_word[15:0], byte_i};
            r_byte_cnt <= r_byte_cnt + 2'd1;
        end
    end

    // word_o is the complete word on the edge where word_valid_o is high.
    assign word_o       = {r_word, byte_i};
    assign word_valid_o = shift_i && (r_byte_cnt == LAST_BYTE);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a 16-bit word count header, writes N words into instruction memory, then starts the CPU.
// Byte handshake: a byte moves on a rising edge where byte_valid_i and byte_ready_o are both high.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        start_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [2:0]  dbg_state_o
);

    localparam logic [16:0]       MAX_COUNT = 17'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

    state_t            r_state;
    state_t            w_next_state;
    logic [15:0]       r_count;
    logic [ADDR_W-1:0] r_word_idx;
    logic              r_mem_we;
    logic [31:0]       r_mem_addr;
    logic [31:0]       r_mem_data;
    logic              r_start;
    logic              r_busy;
    logic              r_err;

    logic              w_ready;
    logic              w_accept;
    logic [15:0]       w_count_full;
    logic              w_count_bad;
    logic              w_last_word;
    logic              w_pack_clear;
    logic              w_pack_shift;
    logic [31:0]       w_word;
    logic              w_word_valid;

    assign w_ready      = (r_state == HDR_HI) || (r_state == HDR_LO) || (r_state == DATA);
    assign w_accept     = byte_valid_i && w_ready;
    assign w_count_full = {r_count[15:8], byte_data_i};
    assign w_count_bad  = (w_count_full == 16'd0) || ({1'b0, w_count_full} > MAX_COUNT);
    assign w_last_word  = (16'(r_word_idx) == (r_count - 16'd1));
    assign w_pack_clear = (r_state == HDR_LO) && w_accept;
    assign w_pack_shift = (r_state == DATA) && w_accept;

    imem_loader_byte_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (w_pack_clear),
        .shift_i      (w_pack_shift),
        .byte_i       (byte_data_i),
        .word_o       (w_word),
        .word_valid_o (w_word_valid)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (load_i) w_next_state = HDR_HI;
            HDR_HI:  if (w_accept) w_next_state = HDR_LO;
            HDR_LO:  if (w_accept) w_next_state = w_count_bad ? ERR : DATA;
            DATA:    if (w_word_valid) w_next_state = WRITE;
            WRITE:   w_next_state = w_last_word ? DONE : DATA;
            DONE:    if (load_i) w_next_state = HDR_HI;
            ERR:     if (load_i) w_next_state = HDR_HI;
            default: w_next_state = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with r_state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_word_idx <= '0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_start  <= (w_next_state == DONE);
            r_err    <= (w_next_state == ERR);
            r_busy   <= (w_next_state == HDR_HI) || (w_next_state == HDR_LO) ||
                        (w_next_state == DATA)   || (w_next_state == WRITE);
            r_mem_we <= (w_next_state == WRITE);

            if ((r_state == HDR_HI) && w_accept) begin
                r_count[15:8] <= byte_data_i;
            end
            if ((r_state == HDR_LO) && w_accept) begin
                r_count    <= w_count_full;
                r_word_idx <= '0;
            end
            // Address and data change only when a write is launched and hold otherwise.
            if ((r_state == DATA) && w_word_valid) begin
                r_mem_addr <= 32'(r_word_idx) << ADDR_SHIFT;
                r_mem_data <= w_word;
            end
            if ((r_state == WRITE) && !w_last_word) begin
                r_word_idx <= r_word_idx + IDX_ONE;
            end
        end
    end

    assign byte_ready_o = w_ready;
    assign mem_we_o     = r_mem_we;
    assign mem_addr_o   = r_mem_addr;
    assign mem_data_o   = r_mem_data;
    assign start_o      = r_start;
    assign busy_o       = r_busy;
    assign err_o        = r_err;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: header vector table, scoreboarded memory writes, directed corner sequences.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        load_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        start_o;
    logic        busy_o;
    logic        err_o;
    logic [2:0]  dbg_state_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic       exp_err;
    } hdr_vec_t;

    hdr_vec_t vecs[7];

    imem_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .load_i       (load_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .start_o      (start_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .dbg_state_o  (dbg_state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Scoreboard: every write pulse must match the oldest expected {addr, data}.
    always @(negedge clk) begin
        if (mem_we_o === 1'b1) begin
            check("ready_low_in_write", 32'(byte_ready_o), 32'd0);
            if (exp_q.size() == 0) begin
                fail_now("unexpected_write", $sformatf("actual addr=0x%08h data=0x%08h, required no write",
                         mem_addr_o, mem_data_o));
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", mem_addr_o, mon_e[63:32]);
                check("write_data", mem_data_o, mon_e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
    endtask

    // acc_cyc is the cycle count seen just before the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps, output int acc_cyc);
        int  waited;
        int  idle;
        bit  rdy;
        if (gaps) begin
            idle = $urandom_range(0, 3);
            byte_valid_i = 1'b0;
            repeat (idle) tick();
        end
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        waited  = 0;
        rdy     = 1'b0;
        acc_cyc = -1;
        while (waited < 100) begin
            @(negedge clk);
            rdy     = byte_ready_o;
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
        end
        if (!rdy) fail_now("byte_accept_timeout", $sformatf("byte 0x%02h not accepted in 100 cycles", b));
    endtask

    task automatic send_header(input logic [15:0] n, input bit gaps, output int c0);
        int d;
        send_byte(n[15:8], gaps, c0);
        send_byte(n[7:0], gaps, d);
    endtask

    task automatic send_word(input logic [31:0] w, input int idx, input bit gaps);
        int d;
        exp_q.push_back({32'(idx * 4), w});
        send_byte(w[31:24], gaps, d);
        send_byte(w[23:16], gaps, d);
        send_byte(w[15:8], gaps, d);
        send_byte(w[7:0], gaps, d);
    endtask

    task automatic wait_done(input int limit, output int c);
        c = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (start_o === 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) fail_now("done_timeout", $sformatf("start_o not high within %0d cycles", limit));
    endtask

    // Data phase of a load already past its header; c0 marks the first header byte.
    task automatic finish_load(input int n, input bit gaps, input int c0, input string tag);
        int cd;
        for (int i = 0; i < n; i++) send_word($urandom, i, gaps);
        byte_valid_i = 1'b0;
        wait_done(30 * n + 50, cd);
        check({tag, "_start"}, 32'(start_o), 32'd1);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        if (!gaps) check({tag, "_latency"}, 32'(cd - c0), 32'(2 + 5 * n));
    endtask

    task automatic load_program(input int n, input bit gaps, input string tag);
        int c0;
        pulse_load();
        send_header(16'(n), gaps, c0);
        finish_load(n, gaps, c0, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         c0;
        int         cd;
        int         d;
        logic [31:0] w1;

        vecs[0] = '{hi: 8'h00, lo: 8'h00, exp_err: 1'b1};
        vecs[1] = '{hi: 8'h01, lo: 8'h01, exp_err: 1'b1};
        vecs[2] = '{hi: 8'h00, lo: 8'h01, exp_err: 1'b0};
        vecs[3] = '{hi: 8'hFF, lo: 8'hFF, exp_err: 1'b1};
        vecs[4] = '{hi: 8'h00, lo: 8'h03, exp_err: 1'b0};
        vecs[5] = '{hi: 8'h80, lo: 8'h00, exp_err: 1'b1};
        vecs[6] = '{hi: 8'h00, lo: 8'h10, exp_err: 1'b0};

        rst_i = 1'b1;
        load_i = 1'b0;
        byte_valid_i = 1'b0;
        byte_data_i = 8'h00;
        repeat (3) tick();
        check("rst_state", 32'(dbg_state_o), 32'(IDLE));
        check("rst_ready", 32'(byte_ready_o), 32'd0);
        check("rst_we", 32'(mem_we_o), 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_data", mem_data_o, 32'd0);
        check("rst_start", 32'(start_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // Reference program N=2, continuous stream.
        pulse_load();
        check("load_hdr_hi", 32'(dbg_state_o), 32'(HDR_HI));
        send_header(16'd2, 1'b0, c0);
        send_word(32'h20080005, 0, 1'b0);
        send_word(32'h01095020, 1, 1'b0);
        byte_valid_i = 1'b0;
        wait_done(100, cd);
        check("n2_latency", 32'(cd - c0), 32'd12);
        check("n2_start", 32'(start_o), 32'd1);
        check("n2_pending", 32'(exp_q.size()), 32'd0);

        // load_i in DONE: start drops, same program reloaded over addr 0 with gappy valid.
        pulse_load();
        check("reload_start_low", 32'(start_o), 32'd0);
        check("reload_state", 32'(dbg_state_o), 32'(HDR_HI));
        send_header(16'd2, 1'b1, c0);
        send_word(32'h20080005, 0, 1'b1);
        send_word(32'h01095020, 1, 1'b1);
        byte_valid_i = 1'b0;
        wait_done(200, cd);
        check("gap_start", 32'(start_o), 32'd1);
        check("gap_pending", 32'(exp_q.size()), 32'd0);

        // Header table: bad counts go to ERR, good ones load random words.
        for (int v = 0; v < 7; v++) begin
            pulse_load();
            check($sformatf("vec%0d_hdr_hi", v), 32'(dbg_state_o), 32'(HDR_HI));
            check($sformatf("vec%0d_busy", v), 32'(busy_o), 32'd1);
            send_header({vecs[v].hi, vecs[v].lo}, 1'b0, c0);
            check($sformatf("vec%0d_err", v), 32'(err_o), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d_ready", v), 32'(byte_ready_o), 32'(!vecs[v].exp_err));
            if (vecs[v].exp_err) begin
                byte_valid_i = 1'b1;
                byte_data_i  = 8'hA5;
                repeat (3) tick();
                byte_valid_i = 1'b0;
                check($sformatf("vec%0d_err_hold", v), 32'(dbg_state_o), 32'(ERR));
                check($sformatf("vec%0d_err_busy", v), 32'(busy_o), 32'd0);
            end else begin
                finish_load(int'({vecs[v].hi, vecs[v].lo}), 1'b0, c0, $sformatf("vec%0d", v));
            end
        end

        // Reset after 1.5 words of an N=3 load.
        pulse_load();
        send_header(16'd3, 1'b0, c0);
        send_word($urandom, 0, 1'b0);
        send_byte(8'h11, 1'b0, d);
        send_byte(8'h22, 1'b0, d);
        byte_valid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("midrst_state", 32'(dbg_state_o), 32'(IDLE));
        check("midrst_start", 32'(start_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_ready", 32'(byte_ready_o), 32'd0);
        check("midrst_addr", mem_addr_o, 32'd0);
        check("midrst_data", mem_data_o, 32'd0);
        check("midrst_pending", 32'(exp_q.size()), 32'd0);
        load_program(3, 1'b0, "after_rst");

        // load_i pulsed mid-word is ignored.
        pulse_load();
        send_header(16'd2, 1'b0, c0);
        send_word($urandom, 0, 1'b0);
        w1 = $urandom;
        exp_q.push_back({32'd4, w1});
        send_byte(w1[31:24], 1'b0, d);
        send_byte(w1[23:16], 1'b0, d);
        byte_valid_i = 1'b0;
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
        check("load_in_data_state", 32'(dbg_state_o), 32'(DATA));
        send_byte(w1[15:8], 1'b0, d);
        send_byte(w1[7:0], 1'b0, d);
        byte_valid_i = 1'b0;
        wait_done(100, cd);
        check("load_in_data_start", 32'(start_o), 32'd1);
        check("load_in_data_pending", 32'(exp_q.size()), 32'd0);

        // Largest program: last write lands at 0x3FC.
        load_program(256, 1'b0, "max");
        check("max_last_addr", mem_addr_o, 32'h0000_03FC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time loader sitting directly upstream of the single-cycle CPU and its Instruction_Memory.
- Accepts a byte stream over a valid/ready handshake.
- Packs bytes into 32-bit big-endian instruction words and writes them into instruction memory through a one-cycle write port.
- Drives the CPU's start_i once the whole program is resident.
- Holds the CPU idle (start_o low) throughout loading.

Parameters:
ADDR_W, 8, word-index width; instruction memory depth is 2**ADDR_W words.
MAX_WORDS, 256, largest accepted program length in words; must be <= 2**ADDR_W.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_i  input  1  reset; synchronous, active-high.
load_i  input  1  begin-load request; sampled only in IDLE, DONE or ERR.
byte_valid_i  input  1  stream byte present.
byte_data_i  input  8  stream byte.
byte_ready_o  output  1  loader can accept a byte this cycle.
mem_we_o  output  1  instruction memory write enable, one-cycle pulse per word.
mem_addr_o  output  32  byte address of the word being written (word_idx*4, upper bits zero).
mem_data_o  output  32  instruction word being written.
start_o  output  1  to CPU start_i; high only in DONE.
busy_o  output  1  high in HDR_HI, HDR_LO, DATA and WRITE.
err_o  output  1  high in ERR.

Behaviour:
- Reset (rst_i=1 at an edge):
  - state=IDLE.
  - All outputs 0; mem_addr_o=0; mem_data_o=0.
  - Byte counter and word index cleared.
  - Reset has priority over every other event, including mid-load. Words already written stay in memory, but start_o stays 0.
- Handshake:
  - A byte transfers when byte_valid_i & byte_ready_o at the edge.
  - byte_ready_o=1 only in HDR_HI, HDR_LO and DATA; it is combinational from state.
  - byte_valid_i may drop at any time. Gaps stall the FSM without data loss.
- Stream format: 16-bit word count N (high byte first), then N*4 instruction bytes. The first byte of each word lands in bits [31:24].
- States:
  - IDLE: load_i=1 -> HDR_HI.
  - HDR_HI: accepted byte -> count[15:8]; go to HDR_LO.
  - HDR_LO: accepted byte -> count[7:0]. Then check the complete count: if it is 0 or > MAX_WORDS -> ERR, else -> DATA, with word_idx=0 and byte_cnt=0.
  - DATA: each accepted byte shifts into the word register (word = {word[23:0], byte}) and increments byte_cnt (2 bits). On the 4th byte (byte_cnt==3 accepted) -> WRITE.
  - WRITE:
    - Lasts exactly one cycle. mem_we_o=1, mem_addr_o={word_idx,2'b00} zero-extended, mem_data_o=assembled word.
    - byte_ready_o=0 in this cycle, so no byte is lost.
    - Next state: DONE if word_idx==N-1, else DATA with word_idx+1.
  - DONE: start_o=1, held until reset or load_i. load_i=1 -> HDR_HI, and start_o drops in the same edge's next cycle.
  - ERR: err_o=1, byte_ready_o=0. load_i=1 -> HDR_HI; otherwise stay.
- load_i in HDR_HI, HDR_LO, DATA or WRITE is ignored.
- mem_addr_o and mem_data_o are registered. They hold their last values outside WRITE; only mem_we_o qualifies them.
- Throughput: 5 cycles per word minimum (4 byte cycles + 1 write). With continuous valid, the total load time is 2 + 5N cycles from the first header byte to DONE.
- Word index never wraps: MAX_WORDS <= 2**ADDR_W, and N is checked before DATA is entered.

Decomposition:
- Shared package:
  - state enum {IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR}.
  - HDR_BYTES=2, BYTES_PER_WORD=4.
  - Address shift constant of 2.
- One natural sub-module: byte_packer. It is a 4-byte shift register with a 2-bit counter, clear input, and word_valid output. The FSM in imem_loader owns header parsing, indexing and the write pulse.

Test Plan:
- Load N=2: bytes 00 02 20 08 00 05 01 09 50 20 with continuous valid -> writes (addr 0, 0x20080005), (addr 4, 0x01095020); start_o=1 exactly 12 cycles after the first header byte is accepted.
- Same stream with byte_valid_i toggled randomly, plus a check that byte_ready_o=0 in WRITE cycles -> identical writes and data; no dropped or duplicated bytes.
- Header 00 00 -> ERR, err_o=1, byte_ready_o=0, no mem_we_o. Header 01 01 with MAX_WORDS=256 -> ERR. A subsequent load_i -> HDR_HI.
- rst_i asserted after 1.5 words of N=3 -> next cycle IDLE, all outputs 0, start_o=0. A fresh load then completes normally.
- load_i pulsed during DATA -> ignored and the load completes unchanged. load_i in DONE -> start_o falls, a new header is accepted, and the new program overwrites from addr 0.
- N=MAX_WORDS=256 with continuous stream -> last write at addr 0x3FC; DONE after 2+1280 cycles.
